// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults, RGB444 colour type, marker colours and the
// pipeline tag carried alongside each pixel of the front-panel path.
package video_timing_pkg;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 110;
    localparam int H_SYNC_DEF   = 40;
    localparam int H_BP_DEF     = 220;
    localparam int V_ACTIVE_DEF = 720;
    localparam int V_FP_DEF     = 5;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 20;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int PIPE_LATENCY = 3;
    localparam int ADDR_WIDTH   = 18;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t COLOR_BLACK       = 12'h000;
    localparam rgb444_t COLOR_LED         = 12'hF00;
    localparam rgb444_t COLOR_SWITCH      = 12'h0F0;
    localparam rgb444_t COLOR_TRANSPARENT = 12'h333;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        hsync;
        logic        vsync;
        logic        frameStart;
        logic        blank;
    } pixel_tag_t;

    function automatic logic [2:0] bar_index(input logic [10:0] x, input int barWidth);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x) >= i * barWidth) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic rgb444_t bar_color(input logic [2:0] idx);
        rgb444_t c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = COLOR_SWITCH;
            3'd4:    c = 12'hF0F;
            3'd5:    c = COLOR_LED;
            3'd6:    c = 12'h00F;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sram_image.sv
// Single-port-write, registered-read block RAM used for the background image
// and its palette; the full 2**ADDR_WIDTH range is addressable.
module sram_image #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wAddr_i,
    input  logic [DATA_WIDTH-1:0] wData_i,
    input  logic [ADDR_WIDTH-1:0] rAddr_i,
    output logic [DATA_WIDTH-1:0] rData_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[wAddr_i] <= wData_i;
        rData_o <= mem[rAddr_i];
    end

endmodule

// File: rtl/video_timing_counter.sv
// Free-running horizontal/vertical raster counters with display-enable,
// sync and frame_start decode, all referring to the current count.
module video_timing_counter import video_timing_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] hCount_o,
    output logic [10:0] vCount_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frameStart_o
);

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_ACTIVE + H_FP;
    localparam int HS_END      = HS_START + H_SYNC;
    localparam int VS_START    = V_ACTIVE + V_FP;
    localparam int VS_END      = VS_START + V_SYNC;

    logic [10:0] hCount_q, hCount_d;
    logic [10:0] vCount_q, vCount_d;
    logic        inHsync, inVsync;

    always_comb begin
        hCount_d = hCount_q + 11'd1;
        vCount_d = vCount_q;
        if (hCount_q == 11'(LINE_LEN - 1)) begin
            hCount_d = 11'd0;
            vCount_d = (vCount_q == 11'(FRAME_LINES - 1)) ? 11'd0 : vCount_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hCount_q <= 11'd0;
            vCount_q <= 11'd0;
        end else begin
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
        end
    end

    // vsync decodes only the line count, so it naturally changes at h=0
    assign inHsync      = (hCount_q >= 11'(HS_START)) && (hCount_q < 11'(HS_END));
    assign inVsync      = (vCount_q >= 11'(VS_START)) && (vCount_q < 11'(VS_END));
    assign hsync_o      = SYNC_POS ? inHsync : !inHsync;
    assign vsync_o      = SYNC_POS ? inVsync : !inVsync;
    assign de_o         = (hCount_q < 11'(H_ACTIVE)) && (vCount_q < 11'(V_ACTIVE));
    assign frameStart_o = (hCount_q == 11'd0) && (vCount_q == 11'd0);
    assign hCount_o     = hCount_q;
    assign vCount_o     = vCount_q;

endmodule

// File: rtl/background_raster_fetch.sv
// Raster timing plus pixel-doubled palette image fetch, 3-cycle aligned outputs.
// Optional colour-bar substitution is compiled in with BG_TEST_PATTERN_EN.
module background_raster_fetch import video_timing_pkg::*; #(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit SYNC_POS  = 1'b1,
    parameter int BG_HEIGHT = 500,
    parameter int BG_SHIFT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        test_pattern,
    output logic [10:0] current_x,
    output logic [10:0] current_y,
    output logic [11:0] background_color,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int IMG_WIDTH = H_ACTIVE >> BG_SHIFT;
    localparam pixel_tag_t TAG_RESET = '{x: 11'd0, y: 11'd0, de: 1'b0,
                                         hsync: ~SYNC_POS, vsync: ~SYNC_POS,
                                         frameStart: 1'b0, blank: 1'b1};

    logic [10:0]           hCount, vCount;
    logic                  cntDe, cntHsync, cntVsync, cntFrameStart;
    logic                  inPanel;
    logic [ADDR_WIDTH-1:0] imgAddr_q, imgAddr_d;
    pixel_tag_t            tag_d;
    pixel_tag_t            tag_q [PIPE_LATENCY];
    pixel_tag_t            outTag;
    logic [3:0]            colorIndex;
    rgb444_t               paletteColor;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POS(SYNC_POS)
    ) timing (
        .clk(clk), .reset(reset),
        .hCount_o(hCount), .vCount_o(vCount),
        .de_o(cntDe), .hsync_o(cntHsync), .vsync_o(cntVsync),
        .frameStart_o(cntFrameStart)
    );

    // Outside the panel the address is held so the RAM sees no extra toggling
    always_comb begin
        inPanel   = (hCount < 11'(H_ACTIVE)) && (vCount < 11'(BG_HEIGHT));
        imgAddr_d = imgAddr_q;
        if (inPanel) begin
            imgAddr_d = ADDR_WIDTH'(vCount >> BG_SHIFT) * ADDR_WIDTH'(IMG_WIDTH)
                      + ADDR_WIDTH'(hCount >> BG_SHIFT);
        end
        tag_d = '{x: hCount, y: vCount, de: cntDe, hsync: cntHsync, vsync: cntVsync,
                  frameStart: cntFrameStart, blank: !inPanel};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LATENCY; i++) tag_q[i] <= TAG_RESET;
            imgAddr_q <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < PIPE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            imgAddr_q <= imgAddr_d;
        end
    end

    sram_image #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(4)) imageRam (
        .clk(clk), .we_i(1'b0), .wAddr_i('0), .wData_i('0),
        .rAddr_i(imgAddr_q), .rData_o(colorIndex)
    );

    sram_image #(.ADDR_WIDTH(4), .DATA_WIDTH(12)) paletteRam (
        .clk(clk), .we_i(1'b0), .wAddr_i('0), .wData_i('0),
        .rAddr_i(colorIndex), .rData_o(paletteColor)
    );

    assign outTag      = tag_q[PIPE_LATENCY-1];
    assign current_x   = outTag.x;
    assign current_y   = outTag.y;
    assign de          = outTag.de;
    assign hsync       = outTag.hsync;
    assign vsync       = outTag.vsync;
    assign frame_start = outTag.frameStart;

`ifdef BG_TEST_PATTERN_EN
    localparam int BAR_WIDTH = H_ACTIVE / 8;

    logic       patternOn_q;
    logic [2:0] barIndex_q;

    // Mode switches only as pixel (0,0) reaches the output, so frames never tear
    always_ff @(posedge clk) begin
        if (reset) begin
            patternOn_q <= 1'b0;
            barIndex_q  <= 3'd0;
        end else begin
            if (tag_q[PIPE_LATENCY-2].frameStart) patternOn_q <= test_pattern;
            barIndex_q <= bar_index(tag_q[PIPE_LATENCY-2].x, BAR_WIDTH);
        end
    end

    always_comb begin
        if (patternOn_q) background_color = outTag.de ? bar_color(barIndex_q) : COLOR_BLACK;
        else             background_color = outTag.blank ? COLOR_BLACK : paletteColor;
    end
`else
    logic unused_testPattern;
    assign unused_testPattern = test_pattern;
    assign background_color   = outTag.blank ? COLOR_BLACK : paletteColor;
`endif

endmodule

// File: tb/tb_background_raster_fetch.sv
// Directed bench for background_raster_fetch on a scaled-down raster (80x30,
// 64x24 active, 16-row panel) so several frames fit in a short run.
`timescale 1ns/1ps
module tb_background_raster_fetch;
    import video_timing_pkg::*;

    localparam int H_ACT = 64;
    localparam int H_FPL = 6;
    localparam int H_SYN = 4;
    localparam int H_BPL = 6;
    localparam int H_TOT = 80;
    localparam int V_ACT = 24;
    localparam int V_FPL = 2;
    localparam int V_SYN = 2;
    localparam int V_BPL = 2;
    localparam int V_TOT = 30;
    localparam int BG_H  = 16;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        test_pattern = 1'b0;
    logic [10:0] current_x, current_y;
    logic [11:0] background_color;
    logic        hsync, vsync, de, frame_start;

    int checkCount = 0;
    int passCount  = 0;
    int pos        = 0;

    always #5 clk = ~clk;

    background_raster_fetch #(
        .H_ACTIVE(H_ACT), .H_FP(H_FPL), .H_SYNC(H_SYN), .H_BP(H_BPL),
        .V_ACTIVE(V_ACT), .V_FP(V_FPL), .V_SYNC(V_SYN), .V_BP(V_BPL),
        .SYNC_POS(1'b1), .BG_HEIGHT(BG_H), .BG_SHIFT(1)
    ) dut (
        .clk(clk), .reset(reset), .test_pattern(test_pattern),
        .current_x(current_x), .current_y(current_y),
        .background_color(background_color),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic rst, input logic tp);
        reset        = rst;
        test_pattern = tp;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic gotoPixel(input int x, input int y);
        stepCycles((y * H_TOT + x - pos + FRAME) % FRAME);
        checkOutput("pos_x", current_x, x);
        checkOutput("pos_y", current_y, y);
    endtask

    // Image addresses: (y>>1)*32 + (x>>1)
    task automatic loadMemories();
        for (int i = 0; i < 256; i++) dut.imageRam.mem[i] = 4'h0;
        for (int i = 0; i < 16; i++) dut.paletteRam.mem[i] = COLOR_TRANSPARENT;
        dut.imageRam.mem[0]   = 4'h1;
        dut.imageRam.mem[1]   = 4'h2;
        dut.imageRam.mem[106] = 4'hA;
        dut.imageRam.mem[107] = 4'h3;
        dut.imageRam.mem[226] = 4'h7;
        dut.paletteRam.mem[1]  = COLOR_LED;
        dut.paletteRam.mem[2]  = COLOR_SWITCH;
        dut.paletteRam.mem[3]  = 12'h123;
        dut.paletteRam.mem[7]  = 12'h5A5;
        dut.paletteRam.mem[10] = 12'hABC;
    endtask

    task automatic checkFillAndOrigin(input string tag);
        @(posedge clk); @(negedge clk);
        checkOutput({tag, "_fill1_de"}, de, 0);
        checkOutput({tag, "_fill1_color"}, background_color, 0);
        @(posedge clk); @(negedge clk);
        checkOutput({tag, "_fill2_de"}, de, 0);
        checkOutput({tag, "_fill2_fs"}, frame_start, 0);
        @(posedge clk); @(negedge clk);
        pos = 0;
        checkOutput({tag, "_origin_fs"}, frame_start, 1);
        checkOutput({tag, "_origin_x"}, current_x, 0);
        checkOutput({tag, "_origin_y"}, current_y, 0);
        checkOutput({tag, "_origin_de"}, de, 1);
        checkOutput({tag, "_origin_hsync"}, hsync, 0);
        checkOutput({tag, "_origin_vsync"}, vsync, 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int deCnt, hsCnt, hsFirst, xErr;
        applyStimulus(1'b1, 1'b0);
        loadMemories();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_de", de, 0);
        checkOutput("rst_hsync", hsync, 0);
        checkOutput("rst_vsync", vsync, 0);
        checkOutput("rst_x", current_x, 0);
        checkOutput("rst_y", current_y, 0);
        checkOutput("rst_fs", frame_start, 0);
        checkOutput("rst_color", background_color, 0);

        applyStimulus(1'b0, 1'b0);
        checkFillAndOrigin("start");
        checkOutput("led_marker", background_color, 12'hF00);

        // One full line: de, hsync window and coordinate sequence
        deCnt = 0; hsCnt = 0; hsFirst = -1; xErr = 0;
        for (int i = 0; i < H_TOT; i++) begin
            if (current_x !== 11'(i) || current_y !== 11'd0) xErr++;
            if (de) deCnt++;
            if (hsync) begin
                hsCnt++;
                if (hsFirst < 0) hsFirst = i;
            end
            if (i == 2) checkOutput("switch_marker", background_color, 12'h0F0);
            if (i == H_ACT) checkOutput("hblank_color", background_color, 0);
            stepCycles(1);
        end
        checkOutput("line_de_count", deCnt, 64);
        checkOutput("line_hs_count", hsCnt, 4);
        checkOutput("line_hs_start", hsFirst, 70);
        checkOutput("line_x_errors", xErr, 0);
        checkOutput("wrap_x", current_x, 0);
        checkOutput("wrap_y", current_y, 1);
        checkOutput("wrap_fs", frame_start, 0);

        // Pixel doubling: (20..21, 6..7) share one image texel
        gotoPixel(20, 6); checkOutput("img_20_6", background_color, 12'hABC);
        gotoPixel(21, 6); checkOutput("img_21_6", background_color, 12'hABC);
        gotoPixel(22, 6); checkOutput("img_22_6", background_color, 12'h123);
        gotoPixel(20, 7); checkOutput("img_20_7", background_color, 12'hABC);
        gotoPixel(21, 7); checkOutput("img_21_7", background_color, 12'hABC);

        // Panel bottom edge and rows below it
        gotoPixel(4, 15); checkOutput("row15_color", background_color, 12'h5A5);
        checkOutput("row15_de", de, 1);
        gotoPixel(4, 16); checkOutput("row16_color", background_color, 0);
        checkOutput("row16_de", de, 1);
        gotoPixel(4, 23); checkOutput("row23_color", background_color, 0);
        checkOutput("row23_de", de, 1);
        gotoPixel(4, 24); checkOutput("row24_de", de, 0);

        gotoPixel(79, 25); checkOutput("vs_before", vsync, 0);
        gotoPixel(0, 26);  checkOutput("vs_first", vsync, 1);
        gotoPixel(79, 27); checkOutput("vs_last", vsync, 1);
        gotoPixel(0, 28);  checkOutput("vs_after", vsync, 0);
        gotoPixel(0, 0);   checkOutput("frame2_fs", frame_start, 1);
        checkOutput("frame2_color", background_color, 12'hF00);

        // Mid-frame reset pulse
        gotoPixel(35, 10);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        checkOutput("midrst_de", de, 0);
        checkOutput("midrst_x", current_x, 0);
        checkOutput("midrst_y", current_y, 0);
        checkOutput("midrst_color", background_color, 0);
        checkOutput("midrst_fs", frame_start, 0);
        applyStimulus(1'b0, 1'b0);
        checkFillAndOrigin("restart");

`ifdef BG_TEST_PATTERN_EN
        gotoPixel(10, 3);
        applyStimulus(1'b0, 1'b1);
        gotoPixel(20, 6);  checkOutput("tp_same_frame", background_color, 12'hABC);
        gotoPixel(0, 0);   checkOutput("tp_bar0", background_color, 12'hFFF);
        gotoPixel(8, 0);   checkOutput("tp_bar1", background_color, 12'hFF0);
        gotoPixel(55, 0);  checkOutput("tp_bar6", background_color, 12'h00F);
        gotoPixel(60, 0);  checkOutput("tp_bar7", background_color, 12'h000);
        gotoPixel(20, 6);  checkOutput("tp_bar2", background_color, 12'h0FF);
        gotoPixel(4, 20);  checkOutput("tp_low_row", background_color, 12'hFFF);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
